frame_sync: RTL

- Bit-level deframer sitting directly downstream of the demodulator; consumes its recovered bit stream and bit-valid qualifier.
- Hunts for an 8-bit sync word, then slices the following fixed-length payload into bytes.
- Uses a flywheel lock to ride through occasional corrupted sync words caused by channel noise.
- Output bytes feed the receive-side packet logic.

---
 rtl/frame_sync_pkg.sv | 25 ++
 rtl/frame_sync_popcount8.sv | 18 +
 rtl/frame_sync.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/frame_sync_pkg.sv
// rtl/frame_sync_pkg.sv - shared types and widths for the frame_sync deframer
//
// Contents:
//   state_t      : deframer state (HUNT, PAYLOAD, CHECK)
//   SYNC_LEN     : sync word length in bits
//   BIT_CNT_W    : width of the bit-in-byte counter
//   BYTE_CNT_W   : width of the payload byte counter
//   miss_cnt_w() : width of the consecutive-miss counter for a given miss limit
package frame_sync_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } state_t;

    localparam int SYNC_LEN   = 8;
    localparam int BIT_CNT_W  = 3;
    localparam int BYTE_CNT_W = 8;

    function automatic int miss_cnt_w(input int miss_limit);
        return $clog2(miss_limit + 1);
    endfunction

endpackage

// File: rtl/frame_sync_popcount8.sv
// rtl/frame_sync_popcount8.sv - combinational 8-bit Hamming weight
//
// Ports:
//   i_data  [7:0] : word whose set bits are counted
//   o_count [3:0] : number of set bits (0..8)
module frame_sync_popcount8 (
    input  logic [7:0] i_data,
    output logic [3:0] o_count
);

    always_comb begin
        o_count = 4'd0;
        for (int i = 0; i < 8; i++) begin
            o_count = o_count + {3'b000, i_data[i]};
        end
    end

endmodule

// File: rtl/frame_sync.sv
// rtl/frame_sync.sv - sync-word hunting deframer with flywheel lock
//
// Ports:
//   i_clk_slow     : bit-rate clock
//   i_rst          : asynchronous active-low reset
//   i_bit_valid    : i_bit_in carries a received bit this cycle
//   i_bit_in       : demodulated bit
//   o_byte_out     : payload byte, MSB is the first received bit
//   o_byte_valid   : one-cycle pulse, o_byte_out is valid
//   o_frame_start  : one-cycle pulse, sync word accepted
//   o_sync_miss    : one-cycle pulse, expected sync bad but lock held
//   o_locked       : frame alignment held
//   o_frame_cnt    : count of accepted sync words, wraps 255 -> 0
module frame_sync
    import frame_sync_pkg::*;
#(
    parameter logic [7:0] SYNC_WORD     = 8'hA5,
    parameter int         PAYLOAD_BYTES = 4,
    parameter int         HUNT_TOL      = 0,
    parameter int         LOCK_TOL      = 1,
    parameter int         MISS_LIMIT    = 2
) (
    input  logic       i_clk_slow,
    input  logic       i_rst,
    input  logic       i_bit_valid,
    input  logic       i_bit_in,
    output logic [7:0] o_byte_out,
    output logic       o_byte_valid,
    output logic       o_frame_start,
    output logic       o_sync_miss,
    output logic       o_locked,
    output logic [7:0] o_frame_cnt
);

    localparam int MISS_W = miss_cnt_w(MISS_LIMIT);

    localparam logic [3:0]            HUNT_TOL_W = 4'(HUNT_TOL);
    localparam logic [3:0]            LOCK_TOL_W = 4'(LOCK_TOL);
    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE  = BYTE_CNT_W'(PAYLOAD_BYTES - 1);
    // miss_cnt + 1 < MISS_LIMIT  <=>  miss_cnt < MISS_LIMIT - 1
    localparam logic [MISS_W-1:0]     MISS_LAST  = MISS_W'(MISS_LIMIT - 1);

    state_t                  r_state;
    logic [SYNC_LEN-1:0]     r_sr;
    logic [3:0]              r_fill;
    logic [BIT_CNT_W-1:0]    r_bit_cnt;
    logic [BYTE_CNT_W-1:0]   r_byte_cnt;
    logic [MISS_W-1:0]       r_miss_cnt;
    logic [7:0]              r_byte_out;
    logic                    r_byte_valid;
    logic                    r_frame_start;
    logic                    r_sync_miss;
    logic                    r_locked;
    logic [7:0]              r_frame_cnt;

    logic [SYNC_LEN-1:0]     w_sr_next;
    logic [3:0]              w_dist;
    logic                    w_fill_full;
    logic                    w_last_bit;

    assign w_sr_next   = {r_sr[SYNC_LEN-2:0], i_bit_in};
    // The bit shifted in on this edge is the 8th (or later) since reset.
    assign w_fill_full = (r_fill >= 4'd7);
    assign w_last_bit  = (r_bit_cnt == 3'd7);

    frame_sync_popcount8 u_popcount (
        .i_data  (w_sr_next ^ SYNC_WORD),
        .o_count (w_dist)
    );

    always_ff @(posedge i_clk_slow or negedge i_rst) begin
        if (!i_rst) begin
            r_state       <= HUNT;
            r_sr          <= '0;
            r_fill        <= '0;
            r_bit_cnt     <= '0;
            r_byte_cnt    <= '0;
            r_miss_cnt    <= '0;
            r_byte_out    <= '0;
            r_byte_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_sync_miss   <= 1'b0;
            r_locked      <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            // Pulses drop on every edge, so gaps never stretch them.
            r_byte_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_sync_miss   <= 1'b0;
            if (i_bit_valid) begin
                r_sr <= w_sr_next;
                if (r_fill != 4'd8) begin
                    r_fill <= r_fill + 4'd1;
                end
                case (r_state)
                    HUNT: begin
                        if (w_fill_full && (w_dist <= HUNT_TOL_W)) begin
                            r_state       <= PAYLOAD;
                            r_frame_start <= 1'b1;
                            r_locked      <= 1'b1;
                            r_frame_cnt   <= r_frame_cnt + 8'd1;
                            r_bit_cnt     <= '0;
                            r_byte_cnt    <= '0;
                            r_miss_cnt    <= '0;
                        end
                    end
                    PAYLOAD: begin
                        if (w_last_bit) begin
                            r_bit_cnt    <= '0;
                            r_byte_out   <= w_sr_next;
                            r_byte_valid <= 1'b1;
                            if (r_byte_cnt == LAST_BYTE) begin
                                r_byte_cnt <= '0;
                                r_state    <= CHECK;
                            end else begin
                                r_byte_cnt <= r_byte_cnt + 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                    CHECK: begin
                        if (w_last_bit) begin
                            r_bit_cnt  <= '0;
                            r_byte_cnt <= '0;
                            if (w_dist <= LOCK_TOL_W) begin
                                r_frame_start <= 1'b1;
                                r_frame_cnt   <= r_frame_cnt + 8'd1;
                                r_miss_cnt    <= '0;
                                r_state       <= PAYLOAD;
                            end else if (r_miss_cnt < MISS_LAST) begin
                                r_sync_miss <= 1'b1;
                                r_miss_cnt  <= r_miss_cnt + 1'b1;
                                r_state     <= PAYLOAD;
                            end else begin
                                // sr is kept so HUNT can re-detect on the very next bit.
                                r_locked   <= 1'b0;
                                r_miss_cnt <= '0;
                                r_state    <= HUNT;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                    default: r_state <= HUNT;
                endcase
            end
        end
    end

    assign o_byte_out    = r_byte_out;
    assign o_byte_valid  = r_byte_valid;
    assign o_frame_start = r_frame_start;
    assign o_sync_miss   = r_sync_miss;
    assign o_locked      = r_locked;
    assign o_frame_cnt   = r_frame_cnt;

endmodule
